// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the IF/DM memory port arbiter
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} arb_state_t;
  typedef enum logic {REQ_IF = 1'b0, REQ_DM = 1'b1} req_id_t;

  localparam int BITS_PER_BYTE    = 8;
  localparam int DEFAULT_AWIDTH   = 32;
  localparam int DEFAULT_DWIDTH   = 32;
  localparam int DEFAULT_BE_WIDTH = DEFAULT_DWIDTH / BITS_PER_BYTE;

  function automatic int be_width(input int dwidth);
    return dwidth / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - winner selection between IF and DM requesters
// Policy: fixed DM > IF by default, alternating on contention with ARB_ROUND_ROBIN_EN.
module arb_select
  import mem_arb_pkg::*;
(
  input  logic    i_if_valid,
  input  logic    i_dm_valid,
  input  req_id_t i_last_grant,
  output req_id_t o_winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    o_winner = REQ_IF;
    if (i_if_valid && i_dm_valid) begin
      o_winner = (i_last_grant == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (i_dm_valid) begin
      o_winner = REQ_DM;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_if_valid, i_last_grant};
  assign o_winner = i_dm_valid ? REQ_DM : REQ_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// Optional round-robin arbitration under ARB_ROUND_ROBIN_EN; one transaction outstanding.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = DEFAULT_AWIDTH,
  parameter int DWIDTH = DEFAULT_DWIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_req_valid,
  output logic                       if_req_ready,
  input  logic [AWIDTH-1:0]          if_addr,
  output logic                       if_rsp_valid,
  output logic [DWIDTH-1:0]          if_rsp_data,
  input  logic                       dm_req_valid,
  output logic                       dm_req_ready,
  input  logic [AWIDTH-1:0]          dm_addr,
  input  logic                       dm_we,
  input  logic [DWIDTH-1:0]          dm_wdata,
  input  logic [be_width(DWIDTH)-1:0] dm_be,
  output logic                       dm_rsp_valid,
  output logic [DWIDTH-1:0]          dm_rsp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [AWIDTH-1:0]          mem_addr,
  output logic                       mem_we,
  output logic [DWIDTH-1:0]          mem_wdata,
  output logic [be_width(DWIDTH)-1:0] mem_be,
  input  logic                       mem_rsp_valid,
  input  logic [DWIDTH-1:0]          mem_rsp_data,
  output logic                       owner,
  output logic                       protocol_err
);

  arb_state_t r_state;
  req_id_t    r_owner;
  logic       r_protocol_err;
  req_id_t    w_last_grant;
  req_id_t    w_winner;
  logic       w_idle;
  logic       w_win_dm;
  logic       w_issue;
  logic       w_rsp;

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_IF;
    end else if (w_issue && mem_req_ready) begin
      r_last_grant <= w_winner;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = REQ_IF;
`endif

  arb_select u_select (
    .i_if_valid   (if_req_valid),
    .i_dm_valid   (dm_req_valid),
    .i_last_grant (w_last_grant),
    .o_winner     (w_winner)
  );

  assign w_idle   = (r_state == IDLE);
  assign w_win_dm = (w_winner == REQ_DM);
  assign w_issue  = w_idle && (w_win_dm ? dm_req_valid : if_req_valid);

  // Fetches are always full-width reads, so they present zero data and all byte lanes.
  assign mem_req_valid = w_issue;
  assign mem_addr      = !w_issue ? '0 : (w_win_dm ? dm_addr : if_addr);
  assign mem_we        = w_issue && w_win_dm && dm_we;
  assign mem_wdata     = (w_issue && w_win_dm) ? dm_wdata : '0;
  assign mem_be        = !w_issue ? '0 : (w_win_dm ? dm_be : '1);

  assign if_req_ready  = w_idle && !w_win_dm && mem_req_ready;
  assign dm_req_ready  = w_idle &&  w_win_dm && mem_req_ready;

  assign w_rsp         = !w_idle && mem_rsp_valid;
  assign if_rsp_valid  = w_rsp && (r_owner == REQ_IF);
  assign dm_rsp_valid  = w_rsp && (r_owner == REQ_DM);
  assign if_rsp_data   = mem_rsp_data;
  assign dm_rsp_data   = mem_rsp_data;

  assign owner         = r_owner;
  assign protocol_err  = r_protocol_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_owner        <= REQ_IF;
      r_protocol_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue && mem_req_ready) begin
            r_owner <= w_winner;
            r_state <= WAIT_RSP;
          end
          if (mem_rsp_valid) begin
            r_protocol_err <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (ARB_ROUND_ROBIN_EN aware)
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid = 1'b0;
  logic        dm_req_ready;
  logic [31:0] dm_addr = '0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data = '0;
  logic        owner;
  logic        protocol_err;

  logic        model_rsp = 1'b0;
  logic        inj_rsp = 1'b0;
  assign mem_rsp_valid = model_rsp | inj_rsp;

  int checks = 0;
  int errors = 0;
  int lat = 2;

  typedef struct {
    bit          is_dm;
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem_arr [int unsigned];

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
    .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .owner(owner), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 32'h0;
  endfunction

  // Memory model: captures handshakes, answers after 'lat' cycles, merges stores by byte.
  initial begin
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    logic [31:0] word;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
      end else if (mem_req_valid && mem_req_ready) begin
        pend  = 1;
        cnt   = lat;
        paddr = mem_addr;
        if (mem_we) begin
          word = rd(mem_addr);
          for (int i = 0; i < 4; i++) if (mem_be[i]) word[8*i +: 8] = mem_wdata[8*i +: 8];
          mem_arr[mem_addr] = word;
        end
      end
      @(posedge clk);
      #1;
      model_rsp = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          model_rsp    = 1'b1;
          mem_rsp_data = rd(paddr);
          pend         = 0;
        end
      end
    end
  end

  // Response monitor: every rsp_valid pops the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rsp_valid && dm_rsp_valid) begin
        checks++; errors++;
        $display("FAIL rsp_both: if_rsp_valid=1 dm_rsp_valid=1, required at most one");
      end else if (if_rsp_valid || dm_rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: if_rsp_valid=%0b dm_rsp_valid=%0b, required none", if_rsp_valid, dm_rsp_valid);
        end else begin
          e = sb.pop_front();
          if (e.is_dm != dm_rsp_valid) begin
            errors++;
            $display("FAIL rsp_port: got dm=%0b, required dm=%0b", dm_rsp_valid, e.is_dm);
          end else if (e.chk && ((e.is_dm ? dm_rsp_data : if_rsp_data) !== e.data)) begin
            errors++;
            $display("FAIL rsp_data: got 0x%08h, required 0x%08h", e.is_dm ? dm_rsp_data : if_rsp_data, e.data);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit is_dm, input logic [31:0] addr, input bit we,
                       input logic [31:0] wdata, input logic [3:0] be, input bit push,
                       output int n_wait);
    bit done = 0;
    n_wait = 0;
    if (push) sb.push_back('{is_dm, !we, we ? 32'h0 : rd(addr)});
    if (is_dm) begin
      dm_req_valid = 1; dm_addr = addr; dm_we = we; dm_wdata = wdata; dm_be = be;
    end else begin
      if_req_valid = 1; if_addr = addr;
    end
    while (!done) begin
      @(negedge clk);
      if (is_dm ? dm_req_ready : if_req_ready) begin
        check("mem_req_valid", mem_req_valid, 1);
        check("mem_addr", mem_addr, addr);
        check("mem_we", mem_we, is_dm ? we : 1'b0);
        check("mem_wdata", mem_wdata, is_dm ? wdata : 32'h0);
        check("mem_be", mem_be, is_dm ? be : 4'hF);
        done = 1;
      end else if (n_wait >= 30) begin
        check("req_timeout", 0, 1);
        done = 1;
      end
      step();
      if (!done) n_wait++;
    end
    if (is_dm) dm_req_valid = 0; else if_req_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Both requesters valid at once; the loser must be granted the cycle after the winner's response.
  task automatic contend(input bit exp_dm_first, input logic [31:0] a_dm, input logic [31:0] a_if);
    bit got_first = 0, got_second = 0, prev_rsp = 0, chk_owner = 0;
    bit acc_if, acc_dm;
    int n = 0;
    if (exp_dm_first) begin
      sb.push_back('{1'b1, 1'b1, rd(a_dm)});
      sb.push_back('{1'b0, 1'b1, rd(a_if)});
    end else begin
      sb.push_back('{1'b0, 1'b1, rd(a_if)});
      sb.push_back('{1'b1, 1'b1, rd(a_dm)});
    end
    dm_req_valid = 1; dm_addr = a_dm; dm_we = 0; dm_wdata = 0; dm_be = 4'hF;
    if_req_valid = 1; if_addr = a_if;
    while (!got_second && n < 60) begin
      @(negedge clk);
      acc_if = if_req_ready && if_req_valid;
      acc_dm = dm_req_ready && dm_req_valid;
      if (chk_owner) begin
        check("owner_after_grant", owner, exp_dm_first);
        chk_owner = 0;
      end
      if (if_req_ready && dm_req_ready) check("both_ready", 1, 0);
      if (!got_first) begin
        if (acc_if || acc_dm) begin
          got_first = 1;
          chk_owner = 1;
          check("first_grant_dm", acc_dm, exp_dm_first);
        end
      end else if (exp_dm_first ? acc_if : acc_dm) begin
        got_second = 1;
        check("second_after_rsp", prev_rsp, 1);
      end
      prev_rsp = exp_dm_first ? dm_rsp_valid : if_rsp_valid;
      step();
      if (acc_if) if_req_valid = 0;
      if (acc_dm) dm_req_valid = 0;
      n++;
    end
    if (!got_second) check("contend_timeout", 0, 1);
    if_req_valid = 0;
    dm_req_valid = 0;
    wait_drain();
  endtask

  initial begin
    int nw;
    mem_arr[32'h0000_0000] = 32'h0000_0013;
    mem_arr[32'h0000_0004] = 32'h0000_0093;
    mem_arr[32'h0000_0008] = 32'h0010_0113;
    mem_arr[32'h0000_000C] = 32'h0020_0193;
    mem_arr[32'h0000_0010] = 32'h0030_0213;
    mem_arr[32'h0000_0100] = 32'h1234_5678;
    mem_arr[32'h0000_0104] = 32'hCAFE_F00D;

    step();
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_owner", owner, 0);
    check("rst_protocol_err", protocol_err, 0);
    step();
    reset = 0;

    // 1: single fetch
    issue(0, 32'h0, 0, 0, 0, 1, nw);
    check("if_ready_cycle0", nw, 0);
    @(negedge clk);
    check("if_owner", owner, 0);
    check("wait_no_req", mem_req_valid, 0);
    step();
    wait_drain();

    // 2: contention after reset, DM first in both builds
    contend(1, 32'h100, 32'h4);

    // 3: partial store, then read back the merged word
    issue(1, 32'h200, 1, 32'hDEAD_BEEF, 4'b0011, 1, nw);
    wait_drain();
    issue(1, 32'h200, 0, 0, 4'hF, 1, nw);
    wait_drain();

    // 2b: contention right after a DM grant
`ifdef ARB_ROUND_ROBIN_EN
    contend(0, 32'h104, 32'h8);
`else
    contend(1, 32'h104, 32'h8);
`endif

    // 4: memory back-pressure
    mem_req_ready = 0;
    if_req_valid = 1;
    if_addr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_valid", mem_req_valid, 1);
      check("stall_if_ready", if_req_ready, 0);
      step();
    end
    mem_req_ready = 1;
    issue(0, 32'hC, 0, 0, 0, 1, nw);
    check("stall_accept_cycle", nw, 0);
    wait_drain();

    // 5: stray response in IDLE
    step();
    inj_rsp = 1;
    @(negedge clk);
    check("stray_if_rsp", if_rsp_valid, 0);
    check("stray_dm_rsp", dm_rsp_valid, 0);
    step();
    inj_rsp = 0;
    @(negedge clk);
    check("perr_set", protocol_err, 1);
    step();
    step();
    @(negedge clk);
    check("perr_sticky", protocol_err, 1);
    step();

    // 6: reset while a DM load is outstanding
    lat = 6;
    issue(1, 32'h104, 0, 0, 4'hF, 0, nw);
    @(negedge clk);
    check("pre_rst_owner", owner, 1);
    step();
    reset = 1;
    if_req_valid = 1;
    if_addr = 32'h10;
    step();
    reset = 0;
    @(negedge clk);
    check("post_rst_owner", owner, 0);
    check("post_rst_perr", protocol_err, 0);
    check("post_rst_req_valid", mem_req_valid, 1);
    check("post_rst_if_ready", if_req_ready, 1);
    step();
    lat = 2;
    sb.push_back('{1'b0, 1'b1, rd(32'h10)});
    check("post_rst_wait_no_req", mem_req_valid, 0);
    if_req_valid = 0;
    wait_drain();

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
